// File: rtl/conv2_window_buf_if.sv
// Pixel-stream and window-tap bundle for conv2_window_buf.
// Carries last_out_buf only when CONV2_BUF_LAST_EN is defined.
interface conv2_window_buf_if #(
    parameter int DATA_BITS = 12,
    parameter int NTAPS     = 25
);
    logic                             valid_in;
    logic [DATA_BITS-1:0]             data_in;
    logic [NTAPS-1:0][DATA_BITS-1:0]  data_out;   // index = row*5 + col
    logic                             valid_out_buf;
`ifdef CONV2_BUF_LAST_EN
    logic                             last_out_buf;

    modport master (output valid_in, data_in, input data_out, valid_out_buf, last_out_buf);
    modport slave  (input valid_in, data_in, output data_out, valid_out_buf, last_out_buf);
`else
    modport master (output valid_in, data_in, input data_out, valid_out_buf);
    modport slave  (input valid_in, data_in, output data_out, valid_out_buf);
`endif
endinterface

// File: rtl/conv2_window_buf.sv
// Streaming 5x5 sliding-window generator for conv stage 2 (in-bounds windows only).
// Optional CONV2_BUF_LAST_EN adds last_out_buf on the final window of each frame.
module conv2_window_buf #(
    parameter int WIDTH     = 12,
    parameter int HEIGHT    = 12,
    parameter int DATA_BITS = 12,
    parameter int KSIZE     = 5
) (
    input  logic              clk,
    input  logic              rst_n,   // active-high despite the name
    conv2_window_buf_if.slave win_if
);
    localparam int CHAIN_LEN = WIDTH * (KSIZE - 1) + KSIZE;
    localparam int NTAPS     = KSIZE * KSIZE;
    localparam int COL_W     = $clog2(WIDTH);
    localparam int ROW_W     = $clog2(HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_EDGE = COL_W'(KSIZE - 1);
    localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(KSIZE - 1);

    typedef logic [DATA_BITS-1:0] pix_t;

    pix_t                            chain_q [CHAIN_LEN];
    pix_t                            chain_d [CHAIN_LEN];
    logic [NTAPS-1:0][DATA_BITS-1:0] tap_q, tap_d;
    logic [COL_W-1:0]                col_q, col_d;
    logic [ROW_W-1:0]                row_q, row_d;
    logic                            valid_q;
    logic                            win_ok;

    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        chain_d = chain_q;
        if (win_if.valid_in) begin
            chain_d[0] = win_if.data_in;
            for (int i = 1; i < CHAIN_LEN; i++) chain_d[i] = chain_q[i-1];
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (win_if.valid_in) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    assign win_ok = win_if.valid_in && (row_q >= ROW_EDGE) && (col_q >= COL_EDGE);

    // Taps are loaded from the post-shift chain, so they include the pixel accepted this edge.
    always_comb begin
        tap_d = tap_q;
        if (win_ok) begin
            for (int r = 0; r < KSIZE; r++)
                for (int c = 0; c < KSIZE; c++)
                    tap_d[r*KSIZE + c] = chain_d[(KSIZE-1-r)*WIDTH + (KSIZE-1-c)];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            // NOTE: the chain is reset so a mid-frame reset leaves no stale pixels behind.
            for (int i = 0; i < CHAIN_LEN; i++) chain_q[i] <= '0;
            tap_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            chain_q <= chain_d;
            tap_q   <= tap_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= win_ok;
        end
    end

    assign win_if.data_out      = tap_q;
    assign win_if.valid_out_buf = valid_q;

`ifdef CONV2_BUF_LAST_EN
    logic last_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) last_q <= 1'b0;
        else       last_q <= win_ok && (col_q == COL_LAST) && (row_q == ROW_LAST);
    end

    assign win_if.last_out_buf = last_q;
`endif
endmodule

// File: tb/tb_conv2_window_buf.sv
// Self-checking bench for conv2_window_buf: directed ramps plus random streams
// compared against a 2-D frame-map reference model.
module tb_conv2_window_buf;
    localparam int W  = 12;
    localparam int H  = 12;
    localparam int DB = 12;
    localparam int K  = 5;
    localparam int NT = K * K;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    conv2_window_buf_if #(.DATA_BITS(DB), .NTAPS(NT)) bus ();

    conv2_window_buf #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .KSIZE(K)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .win_if (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    // Reference model: the current frame as a flat map plus the accept position.
    logic [DB-1:0]          fm [W*H];
    int                     pos = 0;
    logic [NT-1:0][DB-1:0]  exp_taps = '0;
    logic                   exp_valid;
    logic                   exp_last;

    task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at a negedge; the DUT samples on the next posedge and is checked at the following negedge.
    task automatic step(input logic v, input logic [DB-1:0] d);
        int r, c;
        bus.valid_in = v;
        bus.data_in  = d;
        exp_valid    = 1'b0;
        exp_last     = 1'b0;
        if (v) begin
            fm[pos] = d;
            r = pos / W;
            c = pos % W;
            if (r >= K-1 && c >= K-1) begin
                exp_valid = 1'b1;
                for (int kr = 0; kr < K; kr++)
                    for (int kc = 0; kc < K; kc++)
                        exp_taps[kr*K + kc] = fm[(r-(K-1)+kr)*W + (c-(K-1)+kc)];
                exp_last = (pos == W*H - 1);
            end
            pos = (pos + 1) % (W*H);
        end
        @(negedge clk);
        chk("valid_out_buf", bus.valid_out_buf, exp_valid);
        chk("taps", bus.data_out, exp_taps);
`ifdef CONV2_BUF_LAST_EN
        chk("last_out_buf", bus.last_out_buf, exp_last);
`endif
        if (bus.valid_out_buf) pulses++;
    endtask

    // Asserts reset asynchronously at a negedge, checks outputs cleared, releases a cycle later.
    task automatic do_reset();
        rst_n        = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        #1;
        chk("rst_valid", bus.valid_out_buf, 1'b0);
        chk("rst_taps", bus.data_out, '0);
`ifdef CONV2_BUF_LAST_EN
        chk("rst_last", bus.last_out_buf, 1'b0);
`endif
        @(negedge clk);
        rst_n    = 1'b0;
        pos      = 0;
        exp_taps = '0;
    endtask

    // Continuous 0..143 ramp with the spot values the spec pins down.
    task automatic run_ramp(input string pfx);
        int first_idx = -1;
        pulses = 0;
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, DB'(i));
            if (bus.valid_out_buf && first_idx < 0) begin
                first_idx = i;
                chk({pfx, "_first_tap0"},  bus.data_out[0],  0);
                chk({pfx, "_first_tap4"},  bus.data_out[4],  4);
                chk({pfx, "_first_tap5"},  bus.data_out[5],  12);
                chk({pfx, "_first_tap20"}, bus.data_out[20], 48);
                chk({pfx, "_first_tap24"}, bus.data_out[24], 52);
            end
        end
        chk({pfx, "_first_idx"}, first_idx, 52);
        chk({pfx, "_pulses"}, pulses, 64);
        chk({pfx, "_last_tap0"},  bus.data_out[0],  91);
        chk({pfx, "_last_tap24"}, bus.data_out[24], 143);
    endtask

    initial begin
        int first_seen;
        int accepted;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        @(negedge clk);
        do_reset();

        run_ramp("s1");

        // Every other cycle idle, with garbage on data_in while idle.
        pulses = 0;
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, DB'(i));
            step(1'b0, DB'($urandom));
        end
        chk("s2_pulses", pulses, 64);

        // Two frames back to back.
        pulses     = 0;
        first_seen = 0;
        for (int i = 0; i < 2*W*H; i++) begin
            step(1'b1, (i < W*H) ? DB'(i) : DB'(1000 + i - W*H));
            if (i >= W*H && bus.valid_out_buf && first_seen == 0) begin
                first_seen = 1;
                chk("s3_f2_tap0",  bus.data_out[0],  1000);
                chk("s3_f2_tap24", bus.data_out[24], 1052);
            end
        end
        chk("s3_pulses", pulses, 128);

        // Random pixels with random gaps for one full frame.
        pulses   = 0;
        accepted = 0;
        while (accepted < W*H) begin
            if ($urandom_range(0, 2) != 0) begin
                step(1'b1, DB'($urandom));
                accepted++;
            end else begin
                step(1'b0, DB'($urandom));
            end
        end
        chk("s4_pulses", pulses, 64);

        // Mid-frame reset after 70 pixels, then a clean ramp.
        for (int i = 0; i < 70; i++) step(1'b1, DB'($urandom));
        do_reset();
        run_ramp("s5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/conv2_window_buf.md
Name: conv2_window_buf

Overview:
Streaming 5x5 sliding-window generator for the second convolution stage.
- Accepts one DATA_BITS-wide pixel per valid_in cycle, in raster order, from a WIDTH x HEIGHT feature map (pool-1 output).
- Presents all 25 window taps in parallel to the downstream MAC/calc units, with a qualifying valid_out_buf.
- Emits only windows lying fully inside the map (no padding, stride 1): (WIDTH-4) x (HEIGHT-4) windows per frame.

Parameters:
WIDTH, 12, pixels per row of the input map
HEIGHT, 12, rows per frame
DATA_BITS, 12, pixel width; treated as opaque bits, no arithmetic applied
KSIZE, 5, window edge (fixed at 5; tap ports sized for 25)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-high (asserted at 1; name kept per codebase)
valid_in  input  1  data_in carries a valid pixel this cycle
data_in  input  DATA_BITS  pixel, raster order
data_out_0 .. data_out_24  output  DATA_BITS each  window taps; index = row*5 + col; row 0 = oldest row, col 0 = leftmost
valid_out_buf  output  1  taps hold a complete in-bounds window

Behaviour:
- Storage: shift chain of WIDTH*(KSIZE-1)+KSIZE = 53 entries. Shifts by one only on valid_in=1 cycles; holds otherwise.
- Tap mapping, with newest pixel at chain offset 0: data_out_(r*5+c) = chain[(4-r)*WIDTH + (4-c)].
  - data_out_24 = newest pixel.
  - data_out_0 = pixel 4*WIDTH+4 samples older.
- Counters col (0..WIDTH-1) and row (0..HEIGHT-1) track the position of the pixel being accepted.
  - Both advance on valid_in.
  - col wraps to 0 and row increments at col=WIDTH-1.
  - At row=HEIGHT-1, col=WIDTH-1, both wrap to 0 (next frame; no idle cycle required between frames).
- Window valid condition for the accepted pixel: row>=4 and col>=4.
- Latency: taps and valid_out_buf are registered. They update on the clock edge that accepts the pixel and are visible the cycle after valid_in is sampled.
- valid_out_buf = 1 for exactly one cycle per qualifying accepted pixel.
  - valid_out_buf = 0 in any cycle following valid_in=0.
  - Taps hold their last values while valid_out_buf=0.
- Per frame: 64 valid windows for 12x12. Row-edge pixels (col<4) never produce valid_out_buf, so no wrapped windows are emitted.
- Reset (any time, including mid-frame): chain, taps and valid_out_buf go to 0; col and row go to 0. The next accepted pixel is treated as frame index 0.
- Back-to-back frames: the first window of frame N+1 is asserted only after its 53rd pixel. By then no frame-N data remains in the taps.

Optional Feature:
Macro CONV2_BUF_LAST_EN.
- Defined: adds output last_out_buf (1 bit, reset 0). It is asserted together with valid_out_buf on the final window of a frame (pixel row=HEIGHT-1, col=WIDTH-1), and is 0 otherwise.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then stream pixels valued 0..143 continuously -> first valid_out_buf one cycle after pixel 52, with data_out_0=0, data_out_4=4, data_out_5=12, data_out_20=48, data_out_24=52.
- Same stream -> exactly 64 valid_out_buf pulses. None follow pixels with col<4 (e.g. no pulse after pixels 60..63). Last window: data_out_0=91, data_out_24=143. With CONV2_BUF_LAST_EN, last_out_buf=1 only on that pulse.
- Stream with valid_in deasserted every other cycle -> identical tap values per window as the continuous case. valid_out_buf is never high in a cycle following valid_in=0.
- Two frames back-to-back (0..143, then 1000..1143) -> 128 pulses total. Frame-2 first window: data_out_0=1000, data_out_24=1052.
- Assert reset after 70 pixels, then stream 0..143 -> all outputs 0 during reset. First post-reset valid after the 53rd new pixel, with taps exactly as in scenario 1.
